// File: rtl/uart_flow_ctrl.sv
// Byte-port sequencer for mmu_uart_top: drains RX bytes into the host FIFO (consuming host XON/XOFF)
// and arbitrates the transmitter between local XON/XOFF and the response byte stream.
module uart_flow_ctrl #(
  parameter int         CNT_W       = 10,
  parameter int         HI_WM       = 768,
  parameter int         LO_WM       = 256,
  parameter logic [7:0] XON_CHAR    = 8'h11,
  parameter logic [7:0] XOFF_CHAR   = 8'h13,
  parameter bit         FILTER_FLOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx_full,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_tx_busy_n,
  output logic             uart_rd_n,
  output logic             uart_wr_n,
  output logic [7:0]       uart_tx_data,
  input  logic             rxf_full,
  input  logic [CNT_W-1:0] rxf_count,
  output logic             rxf_wr_en,
  output logic [7:0]       rxf_din,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             xoff_sent,
  output logic             remote_paused,
  output logic             overflow_err
);

  localparam logic [CNT_W-1:0] HI_LVL = CNT_W'(HI_WM);
  localparam logic [CNT_W-1:0] LO_LVL = CNT_W'(LO_WM);

  typedef enum logic [1:0] {RX_IDLE, RX_READ, RX_GAP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WR, TX_HOLD, TX_BUSY} tx_state_t;

  rx_state_t  rx_state;
  tx_state_t  tx_state;
  logic       need_xoff;
  logic       need_xon;
  logic       rx_flow;
  logic       rx_elig;
  logic       tx_acc;
  logic       pend_vld;
  logic [7:0] pend_byte;

  function automatic logic is_flow(input logic [7:0] b);
    return FILTER_FLOW && (b == XON_CHAR || b == XOFF_CHAR);
  endfunction

  assign need_xoff = (rxf_count >= HI_LVL) & ~xoff_sent;
  assign need_xon  = (rxf_count <= LO_LVL) & xoff_sent;
  assign rx_flow   = is_flow(uart_rx_data);
  assign rx_elig   = uart_rx_full & (~rxf_full | rx_flow);
  assign tx_acc    = tx_valid & tx_ready;

  // RX path: flow chars are consumed even when the host FIFO is full
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state      <= RX_IDLE;
      uart_rd_n     <= 1'b1;
      rxf_wr_en     <= 1'b0;
      rxf_din       <= 8'h00;
      remote_paused <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_elig) begin
            rx_state  <= RX_READ;
            uart_rd_n <= 1'b0;
            if (rx_flow) begin
              remote_paused <= (uart_rx_data == XOFF_CHAR);
            end else begin
              rxf_wr_en <= 1'b1;
              rxf_din   <= uart_rx_data;
            end
          end else if (uart_rx_full && xoff_sent) begin
            overflow_err <= 1'b1;
          end
        end
        RX_READ: begin
          uart_rd_n <= 1'b1;
          rxf_wr_en <= 1'b0;
          rx_state  <= RX_GAP;
        end
        RX_GAP:  rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // TX path: an accepted response byte that loses to a control char waits in pend_byte
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state     <= TX_IDLE;
      uart_wr_n    <= 1'b1;
      uart_tx_data <= 8'h00;
      tx_ready     <= 1'b0;
      xoff_sent    <= 1'b0;
      pend_vld     <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (uart_tx_busy_n && (need_xoff || need_xon)) begin
            uart_wr_n    <= 1'b0;
            uart_tx_data <= need_xoff ? XOFF_CHAR : XON_CHAR;
            xoff_sent    <= need_xoff;
            tx_state     <= TX_WR;
            if (tx_acc) begin
              pend_vld  <= 1'b1;
              pend_byte <= tx_data;
            end
          end else if (uart_tx_busy_n && (pend_vld || tx_acc)) begin
            uart_wr_n    <= 1'b0;
            uart_tx_data <= pend_vld ? pend_byte : tx_data;
            pend_vld     <= 1'b0;
            tx_state     <= TX_WR;
          end else begin
            tx_ready <= uart_tx_busy_n & ~remote_paused;
            if (tx_acc) begin
              pend_vld  <= 1'b1;
              pend_byte <= tx_data;
            end
          end
        end
        TX_WR: begin
          uart_wr_n <= 1'b1;
          tx_state  <= TX_HOLD;
        end
        TX_HOLD: tx_state <= TX_BUSY;
        TX_BUSY: if (uart_tx_busy_n) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
